// File: rtl/counter_check_reader.sv
// ============================================================================
// counter_check_reader
// ----------------------------------------------------------------------------
// Read side of the counter test stream on a 32-bit slave-FIFO bus. Words are
// drained from the FIFO with OE_n/RD_n while FLAG_EMPTY_n shows data. Each
// captured word is checked against an incrementing pattern (previous + 1,
// modulo 2^32). Results are reported on active-low LEDs, a sticky ERROR bit
// and counters, for bring-up of the host-to-device direction.
//
// Parameters
//   READ_LATENCY  cycles from RD_n sampled low to the matching word on DQ
//                 (supported range 1..4)
//   ERR_CNT_W     width of the saturating mismatch counter
//
// Ports
//   PCLK          in   1          clock, all logic on the rising edge
//   RESET         in   1          synchronous, active-high reset
//   FLAG_EMPTY_n  in   1          0 = FIFO empty, 1 = data available
//   DQ            in   32         FIFO read data
//   OE_n          out  1          FIFO output enable, active low
//   RD_n          out  1          FIFO read strobe, one word per low cycle
//   DATA_VALID    out  1          one-cycle pulse per captured word
//   DATA          out  32         last captured word
//   WORD_CNT      out  32         words captured since reset (wraps)
//   ERR_CNT       out  ERR_CNT_W  mismatch count (saturates at all-ones)
//   ERROR         out  1          sticky mismatch flag, cleared by RESET only
//   LED           out  8          active low: ERROR ? 8'h00 : ~DATA[31:24]
// ============================================================================
module counter_check_reader #(
    parameter int READ_LATENCY = 2,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    input  logic                 FLAG_EMPTY_n,
    input  logic [31:0]          DQ,
    output logic                 OE_n,
    output logic                 RD_n,
    output logic                 DATA_VALID,
    output logic [31:0]          DATA,
    output logic [31:0]          WORD_CNT,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 ERROR,
    output logic [7:0]           LED
);

    // ------------------------------------------------------------------------
    // Bus-side FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OE    = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // DRAIN lasts exactly READ_LATENCY cycles; the counter counts 0..LAT-1.
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_drain_cnt;
    logic [2:0]  w_drain_cnt_next;
    logic        w_oe_n;
    logic        w_rd_strobe;

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // The read strobe is gated by the live flag, so no read is ever issued in
    // a cycle where the FIFO reports empty, even mid-burst.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_oe_n           = 1'b1;
        w_rd_strobe      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (FLAG_EMPTY_n) begin
                    w_state_next = S_OE;
                end
            end

            S_OE: begin
                // One cycle of output enable before the first strobe so the
                // FIFO has turned its bus drivers on.
                w_oe_n       = 1'b0;
                w_state_next = S_READ;
            end

            S_READ: begin
                w_oe_n = 1'b0;
                if (FLAG_EMPTY_n) begin
                    w_rd_strobe = 1'b1;
                end else begin
                    w_state_next     = S_DRAIN;
                    w_drain_cnt_next = '0;
                end
            end

            S_DRAIN: begin
                // Keep OE asserted while words already requested are still
                // arriving on DQ; the flag is deliberately not looked at here.
                w_oe_n           = 1'b0;
                w_drain_cnt_next = r_drain_cnt + 3'd1;
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next     = S_IDLE;
                    w_drain_cnt_next = '0;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign OE_n = w_oe_n;
    assign RD_n = ~w_rd_strobe;

    // ------------------------------------------------------------------------
    // Read pipeline: one bit per issued strobe, delayed by READ_LATENCY so the
    // tap lines up with the cycle in which the FIFO presents the word.
    // ------------------------------------------------------------------------
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic                    w_capture;

    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge PCLK) begin
                    if (RESET) begin
                        r_rd_pipe[gi] <= 1'b0;
                    end else begin
                        r_rd_pipe[gi] <= w_rd_strobe;
                    end
                end
            end else begin : g_stage
                always_ff @(posedge PCLK) begin
                    if (RESET) begin
                        r_rd_pipe[gi] <= 1'b0;
                    end else begin
                        r_rd_pipe[gi] <= r_rd_pipe[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign w_capture = r_rd_pipe[READ_LATENCY-1];

    // ------------------------------------------------------------------------
    // Capture and pattern check
    // ------------------------------------------------------------------------
    logic [31:0]          r_data;
    logic                 r_data_valid;
    logic [31:0]          r_word_cnt;
    logic [31:0]          r_expected;
    logic                 r_seeded;
    logic                 r_error;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [7:0]           r_led;
    logic                 w_mismatch;
    logic                 w_err_cnt_full;

    // The very first word after reset only seeds the expectation.
    assign w_mismatch     = r_seeded && (DQ != r_expected);
    assign w_err_cnt_full = &r_err_cnt;

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_word_cnt   <= '0;
            r_expected   <= '0;
            r_seeded     <= 1'b0;
            r_error      <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_data_valid <= w_capture;
            if (w_capture) begin
                r_data     <= DQ;
                r_word_cnt <= r_word_cnt + 32'd1;
                // Always resync to the received word: a single dropped word
                // costs one error instead of an error on every later word.
                // The +1 wraps naturally, so FFFFFFFF -> 00000000 is legal.
                r_expected <= DQ + 32'd1;
                r_seeded   <= 1'b1;
                if (w_mismatch) begin
                    r_error <= 1'b1;
                    if (!w_err_cnt_full) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // LED image is built from the registered status, so it trails DATA/ERROR
    // by one cycle.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_led <= 8'hFF;
        end else begin
            r_led <= r_error ? 8'h00 : ~r_data[31:24];
        end
    end

    assign DATA       = r_data;
    assign DATA_VALID = r_data_valid;
    assign WORD_CNT   = r_word_cnt;
    assign ERR_CNT    = r_err_cnt;
    assign ERROR      = r_error;
    assign LED        = r_led;

endmodule

// File: tb/tb_counter_check_reader.sv
// ============================================================================
// tb_counter_check_reader
// ----------------------------------------------------------------------------
// Directed bench for counter_check_reader with a latency-2 FIFO model.
// A table of bursts (word list + expected end state) is replayed after a reset
// each, followed by hand-written sequences for exact latency, flag drop
// mid-burst and reset mid-read.
// ============================================================================
module tb_counter_check_reader;

    logic        PCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLAG_EMPTY_n;
    logic [31:0] DQ = 32'd0;
    logic        OE_n;
    logic        RD_n;
    logic        DATA_VALID;
    logic [31:0] DATA;
    logic [31:0] WORD_CNT;
    logic [15:0] ERR_CNT;
    logic        ERROR;
    logic [7:0]  LED;

    always #5 PCLK = ~PCLK;

    counter_check_reader #(
        .READ_LATENCY(2),
        .ERR_CNT_W   (16)
    ) dut (
        .PCLK        (PCLK),
        .RESET       (RESET),
        .FLAG_EMPTY_n(FLAG_EMPTY_n),
        .DQ          (DQ),
        .OE_n        (OE_n),
        .RD_n        (RD_n),
        .DATA_VALID  (DATA_VALID),
        .DATA        (DATA),
        .WORD_CNT    (WORD_CNT),
        .ERR_CNT     (ERR_CNT),
        .ERROR       (ERROR),
        .LED         (LED)
    );

    // ------------------------------------------------------------------------
    // FIFO model: a strobe sampled at edge E pops a word into a holding stage;
    // the word reaches DQ at the following edge (read latency 2).
    // wr_ptr is written only by the stimulus process, rd_ptr only here.
    // ------------------------------------------------------------------------
    logic [31:0] fifo_mem [256];
    int unsigned wr_ptr    = 0;
    int unsigned rd_ptr    = 0;
    logic [31:0] fifo_s1   = 32'd0;
    int unsigned rd_lows   = 0;
    int unsigned underruns = 0;
    int unsigned oe_starts = 0;
    logic        oe_n_d    = 1'b1;

    assign FLAG_EMPTY_n = (wr_ptr != rd_ptr);

    always @(posedge PCLK) begin
        if (!RD_n) begin
            rd_lows <= rd_lows + 1;
            if (wr_ptr != rd_ptr) begin
                fifo_s1 <= fifo_mem[rd_ptr % 256];
                rd_ptr  <= rd_ptr + 1;
            end else begin
                underruns <= underruns + 1;
            end
        end
        DQ     <= fifo_s1;
        oe_n_d <= OE_n;
        if (oe_n_d && !OE_n) begin
            oe_starts <= oe_starts + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_oe_n"},  32'(OE_n),       32'd1);
        check({tag, "_rd_n"},  32'(RD_n),       32'd1);
        check({tag, "_valid"}, 32'(DATA_VALID), 32'd0);
        check({tag, "_data"},  DATA,            32'd0);
        check({tag, "_wcnt"},  WORD_CNT,        32'd0);
        check({tag, "_ecnt"},  32'(ERR_CNT),    32'd0);
        check({tag, "_error"}, 32'(ERROR),      32'd0);
        check({tag, "_led"},   32'(LED),        32'h0000_00FF);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        RESET = 1'b1;
        @(negedge PCLK);
        RESET = 1'b0;
    endtask

    // Wait until the FSM is back in IDLE with an empty FIFO (bounded).
    task automatic wait_burst(input string tag);
        bit done;
        done = 1'b0;
        repeat (2) @(negedge PCLK);
        for (int i = 0; i < 300; i++) begin
            if (OE_n && !FLAG_EMPTY_n) begin
                done = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        repeat (2) @(negedge PCLK);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Wait for the first RD_n-low cycle (bounded), sampled at a negedge.
    task automatic wait_rd_low(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (!RD_n) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_rd_seen"}, 32'(seen), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Burst table
    // ------------------------------------------------------------------------
    typedef struct {
        int          start;
        int          count;
        logic [31:0] exp_data;
        logic [31:0] exp_wcnt;
        logic [15:0] exp_ecnt;
        logic        exp_error;
        logic [7:0]  exp_led;
    } vec_t;

    localparam int NVEC = 7;
    vec_t        vecs [NVEC];
    logic [31:0] pool [40];

    initial begin
        int unsigned lows0;
        int unsigned oe0;

        // ---------------- table setup ----------------
        for (int i = 0; i < 16; i++) pool[i] = 32'h10 + 32'(i);
        pool[16] = 32'd5;  pool[17] = 32'd6;  pool[18] = 32'd7;
        pool[19] = 32'd9;  pool[20] = 32'd10;
        pool[21] = 32'hFFFF_FFFE; pool[22] = 32'hFFFF_FFFF;
        pool[23] = 32'h0000_0000; pool[24] = 32'h0000_0001;
        pool[25] = 32'h7F00_0000; pool[26] = 32'h7F00_0001;
        pool[27] = 32'd1; pool[28] = 32'd3; pool[29] = 32'd5;
        pool[30] = 32'd7; pool[31] = 32'd9;
        pool[32] = 32'hDEAD_BEEF;
        pool[33] = 32'd100; pool[34] = 32'd50; pool[35] = 32'd51; pool[36] = 32'd52;
        for (int i = 37; i < 40; i++) pool[i] = 32'd0;

        //          start cnt  data          wcnt   ecnt   err   led
        vecs[0] = '{0,    16, 32'h0000_001F, 32'd16, 16'd0, 1'b0, 8'hFF};
        vecs[1] = '{16,   5,  32'd10,        32'd5,  16'd1, 1'b1, 8'h00};
        vecs[2] = '{21,   4,  32'd1,         32'd4,  16'd0, 1'b0, 8'hFF};
        vecs[3] = '{25,   2,  32'h7F00_0001, 32'd2,  16'd0, 1'b0, 8'h80};
        vecs[4] = '{27,   5,  32'd9,         32'd5,  16'd4, 1'b1, 8'h00};
        vecs[5] = '{32,   1,  32'hDEAD_BEEF, 32'd1,  16'd0, 1'b0, 8'h21};
        vecs[6] = '{33,   4,  32'd52,        32'd4,  16'd1, 1'b1, 8'h00};

        // ---------------- reset values and idle with empty FIFO ----------------
        RESET = 1'b1;
        repeat (3) @(negedge PCLK);
        RESET = 1'b0;
        check_reset_values("por");
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge PCLK);
                if (!OE_n || !RD_n) bad++;
            end
            check("idle_strobes", 32'(bad), 32'd0);
            check("idle_led", 32'(LED), 32'h0000_00FF);
            check("idle_wcnt", WORD_CNT, 32'd0);
        end
        $display("seq idle: 20 empty cycles, oe_n=%0b rd_n=%0b led=%02h", OE_n, RD_n, LED);

        // ---------------- table-driven bursts ----------------
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            lows0 = rd_lows;
            for (int k = 0; k < vecs[v].count; k++) push(pool[vecs[v].start + k]);
            wait_burst($sformatf("v%0d", v));
            check($sformatf("v%0d_rd_lows", v), rd_lows - lows0, 32'(vecs[v].count));
            check($sformatf("v%0d_data", v),  DATA,          vecs[v].exp_data);
            check($sformatf("v%0d_wcnt", v),  WORD_CNT,      vecs[v].exp_wcnt);
            check($sformatf("v%0d_ecnt", v),  32'(ERR_CNT),  32'(vecs[v].exp_ecnt));
            check($sformatf("v%0d_error", v), 32'(ERROR),    32'(vecs[v].exp_error));
            check($sformatf("v%0d_led", v),   32'(LED),      32'(vecs[v].exp_led));
            $display("vec %0d: %0d words, data=%08h wcnt=%0d ecnt=%0d error=%0b led=%02h",
                     v, vecs[v].count, DATA, WORD_CNT, ERR_CNT, ERROR, LED);
        end

        // ---------------- exact capture latency ----------------
        do_reset();
        lows0 = rd_lows;
        push(32'h1122_3344);
        wait_rd_low("lat");
        @(negedge PCLK);
        check("lat_valid_c1", 32'(DATA_VALID), 32'd0);
        @(negedge PCLK);
        check("lat_valid_c2", 32'(DATA_VALID), 32'd0);
        @(negedge PCLK);
        check("lat_valid_c3", 32'(DATA_VALID), 32'd1);
        check("lat_data_c3",  DATA,            32'h1122_3344);
        check("lat_led_c3",   32'(LED),        32'h0000_00FF);
        @(negedge PCLK);
        check("lat_valid_c4", 32'(DATA_VALID), 32'd0);
        check("lat_led_c4",   32'(LED),        32'h0000_00EE);
        wait_burst("lat");
        check("lat_rd_lows", rd_lows - lows0, 32'd1);
        $display("seq latency: data=%08h led=%02h", DATA, LED);

        // ---------------- flag drops after 3 reads, then resumes ----------------
        do_reset();
        lows0 = rd_lows;
        oe0   = oe_starts;
        push(32'd100); push(32'd101); push(32'd102);
        wait_burst("drop");
        check("drop_rd_lows", rd_lows - lows0, 32'd3);
        check("drop_wcnt",    WORD_CNT,        32'd3);
        check("drop_data",    DATA,            32'd102);
        check("drop_oe_n",    32'(OE_n),       32'd1);
        push(32'd103); push(32'd104);
        wait_burst("resume");
        check("resume_oe_starts", oe_starts - oe0, 32'd2);
        check("resume_rd_lows",   rd_lows - lows0, 32'd5);
        check("resume_wcnt",      WORD_CNT,        32'd5);
        check("resume_data",      DATA,            32'd104);
        check("resume_error",     32'(ERROR),      32'd0);
        $display("seq drop/resume: wcnt=%0d data=%0d error=%0b", WORD_CNT, DATA, ERROR);

        // ---------------- reset pulsed mid-READ ----------------
        do_reset();
        for (int k = 0; k < 8; k++) push(32'd200 + 32'(k));
        wait_rd_low("rst");
        repeat (2) @(negedge PCLK);
        RESET = 1'b1;
        @(negedge PCLK);
        RESET = 1'b0;
        check_reset_values("rst_mid");
        wait_burst("rst");
        check("rst_wcnt",  WORD_CNT,     32'd5);
        check("rst_data",  DATA,         32'd207);
        check("rst_error", 32'(ERROR),   32'd0);
        check("rst_ecnt",  32'(ERR_CNT), 32'd0);
        $display("seq reset mid-read: wcnt=%0d data=%0d error=%0b", WORD_CNT, DATA, ERROR);

        check("no_underrun", 32'(underruns), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
